// File: rtl/adder_bist.sv
// Exhaustive BIST controller for the switch-to-LED ripple-carry adder.
// Optional build macro: STOP_ON_FIRST_FAIL_EN (end the run at the first mismatch).
module adder_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [2*WIDTH:0]     sw_out,
    input  logic [WIDTH:0]       ledr_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [2*WIDTH:0]     fail_vec
);

    localparam int VW = 2 * WIDTH + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        COMPARE,
        FINISHED
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic [15:0]     err_q, err_d;
    logic [VW-1:0]   fail_q, fail_d;
    logic            first_q, first_d;

    logic [WIDTH:0]  expected;
    logic            mismatch;

    always_comb begin
        expected = {1'b0, vec_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, vec_q[WIDTH-1:0]}
                 + {{WIDTH{1'b0}}, vec_q[2*WIDTH]};
        mismatch = (ledr_in != expected);
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        wait_d  = wait_q;
        err_d   = err_q;
        fail_d  = fail_q;
        first_d = first_q;

        case (state_q)
            IDLE, FINISHED: begin
                if (start) begin
                    vec_d   = '0;
                    wait_d  = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    first_d = 1'b0;
                    state_d = SETTLING;
                end
            end
            SETTLING: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = COMPARE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            COMPARE: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 16'd1;
                    end
                    if (!first_q) begin
                        fail_d  = vec_q;
                        first_d = 1'b1;
                    end
                end
`ifdef STOP_ON_FIRST_FAIL_EN
                if (mismatch || vec_q == '1) begin
                    state_d = FINISHED;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = SETTLING;
                end
`else
                if (vec_q == '1) begin
                    state_d = FINISHED;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = SETTLING;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            first_q <= first_d;
        end
    end

    // vec_q is zero in IDLE and keeps the last applied vector in FINISHED
    always_comb begin
        sw_out    = vec_q;
        busy      = (state_q == SETTLING) || (state_q == COMPARE);
        done      = (state_q == FINISHED);
        pass      = (state_q == FINISHED) && (err_q == '0);
        err_count = err_q;
        fail_vec  = fail_q;
    end

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: a faultable adder drives ledr_in, a run-level model predicts outputs.
module tb_adder_bist;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 2;
    localparam int NVEC   = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  sw_out;
    logic [4:0]  ledr_in;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [8:0]  fail_vec;

    int fault = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    adder_bist #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sw_out    (sw_out),
        .ledr_in   (ledr_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    always #5 clk = ~clk;

    // Adder under test with optional stuck bits: 1 = co stuck at 0, 2 = s[0] stuck at 1
    always_comb begin
        logic [4:0] s;
        s = 5'(sw_out[7:4]) + 5'(sw_out[3:0]) + 5'(sw_out[8]);
        if (fault == 1) s[4] = 1'b0;
        if (fault == 2) s[0] = 1'b1;
        ledr_in = s;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-run expectations derived from integer arithmetic over all vectors
    int e_len, e_err, e_fail, e_last;
    task automatic predict(input int mode);
        int errs, first, s, r;
        errs = 0; first = -1;
        for (int v = 0; v < NVEC; v++) begin
            s = ((v >> 4) & 15) + (v & 15) + (v >> 8);
            r = s;
            if (mode == 1) r = s & 15;
            if (mode == 2) r = s | 1;
            if (r != s) begin
                errs++;
                if (first < 0) first = v;
            end
        end
`ifdef STOP_ON_FIRST_FAIL_EN
        if (first >= 0) begin
            e_len = (first + 1) * (SETTLE + 1); e_err = 1; e_fail = first; e_last = first;
        end else begin
            e_len = NVEC * (SETTLE + 1); e_err = 0; e_fail = 0; e_last = NVEC - 1;
        end
`else
        e_len  = NVEC * (SETTLE + 1);
        e_err  = errs;
        e_fail = (first < 0) ? 0 : first;
        e_last = NVEC - 1;
`endif
    endtask

    // Cycle-level model: time since the accepted start determines everything
    logic m_active = 1'b0, m_done = 1'b0;
    int   m_t = 0, m_len = 0, m_err = 0, m_fail = 0, m_last = 0;
    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0; m_done <= 1'b0; m_t <= 0;
            m_err <= 0; m_fail <= 0; m_last <= 0;
        end else if (start && !m_active) begin
            m_active <= 1'b1; m_done <= 1'b0; m_t <= 0;
            m_len <= e_len; m_err <= e_err; m_fail <= e_fail; m_last <= e_last;
        end else if (m_active) begin
            if (m_t + 1 == m_len) begin
                m_active <= 1'b0; m_done <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_done));
            check("sw_out", 32'(sw_out),
                  m_active ? 32'(m_t / (SETTLE + 1)) : (m_done ? 32'(m_last) : 32'd0));
            if (!m_active) begin
                check("err_count", 32'(err_count), m_done ? 32'(m_err) : 32'd0);
                check("fail_vec", 32'(fail_vec), m_done ? 32'(m_fail) : 32'd0);
                check("pass", 32'(pass), 32'(m_done && m_err == 0));
            end
        end
    end

    int busy_cycles;
    logic finished;

    task automatic do_run(input int mode, input int pulse_a, input int pulse_b, input int rst_at);
        @(posedge clk); #1;
        fault = mode;
        predict(mode);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cycles = 0;
        finished = 1'b0;
        for (int i = 1; i < 4000; i++) begin
            start = (i == pulse_a) || (i == pulse_b);
            reset = (i == rst_at);
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done || (rst_at > 0 && i == rst_at + 1)) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        reset = 1'b0;
        check("run_terminated", 32'(finished), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sw", 32'(sw_out), 32'd0);

        do_run(0, -1, -1, -1);
        check("golden_len", busy_cycles, 32'd1536);
        check("golden_err", 32'(err_count), 32'd0);
        check("golden_pass", 32'(pass), 32'd1);
        check("golden_fail_vec", 32'(fail_vec), 32'd0);

        do_run(1, -1, -1, -1);
`ifdef STOP_ON_FIRST_FAIL_EN
        check("co0_len", busy_cycles, 32'd96);
        check("co0_err", 32'(err_count), 32'd1);
        check("co0_sw", 32'(sw_out), 32'h01F);
`else
        check("co0_len", busy_cycles, 32'd1536);
        check("co0_err", 32'(err_count), 32'd256);
`endif
        check("co0_pass", 32'(pass), 32'd0);
        check("co0_fail_vec", 32'(fail_vec), 32'h01F);

        do_run(2, -1, -1, -1);
`ifdef STOP_ON_FIRST_FAIL_EN
        check("s0_len", busy_cycles, 32'd3);
        check("s0_err", 32'(err_count), 32'd1);
`else
        check("s0_len", busy_cycles, 32'd1536);
        check("s0_err", 32'(err_count), 32'd256);
`endif
        check("s0_fail_vec", 32'(fail_vec), 32'd0);

        do_run(1, -1, -1, 700);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sw", 32'(sw_out), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_fail_vec", 32'(fail_vec), 32'd0);

        do_run(0, -1, -1, -1);
        check("post_rst_len", busy_cycles, 32'd1536);
        check("post_rst_pass", 32'(pass), 32'd1);

`ifdef STOP_ON_FIRST_FAIL_EN
        do_run(0, 10, 900, -1);
        check("ignore_start_len", busy_cycles, 32'd1536);
        check("ignore_start_err", 32'(err_count), 32'd0);
`else
        do_run(2, 10, 900, -1);
        check("ignore_start_len", busy_cycles, 32'd1536);
        check("ignore_start_err", 32'(err_count), 32'd256);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
